// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared types and constants for the load/store unit.
//
//   Contents:
//     lsu_state_t  - FSM state encoding of lsu_ctrl
//     F3_*         - RV32 load/store funct3 size/sign codes
//     LSU_DW       - the only supported data width
//     f3_bytes     - access size in bytes for a legal funct3
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LSU_DW = 32;

  // Access size in bytes; only meaningful for funct3 codes that pass the
  // legality check (bits [1:0] select byte/half/word).
  function automatic logic [2:0] f3_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   f3_bytes = 3'd1;
      2'b01:   f3_bytes = 3'd2;
      default: f3_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
//   Bundles the CPU request/response handshake and the data-memory port of
//   the load/store unit.
//
//   Modports:
//     slave  - the load/store unit itself: receives requests, returns
//              responses, drives the memory address/write port, reads mem_rd.
//     master - the surrounding environment: the CPU request source together
//              with the word-organised data memory.
//
//   Signals:
//     req_valid/req_ready     request handshake
//     req_we/req_funct3       store flag and RV32 size/sign code
//     req_addr/req_wdata      byte address and store data
//     resp_valid              one-cycle completion pulse
//     resp_rdata/resp_err     registered load result and error flag
//     mem_addr                word index into data memory
//     mem_wr_en/mem_wd        memory write strobe and data
//     mem_rd                  combinational memory read data
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic                     mem_wr_en;
  logic [DATA_WIDTH-1:0]    mem_wd;
  logic [DATA_WIDTH-1:0]    mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wr_en, mem_wd
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wr_en, mem_wd
  );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane logic for the load/store unit.
//
//   Ports:
//     i_we          1 = store, 0 = load
//     i_funct3      RV32 funct3 size/sign code
//     i_addr_lo     byte offset within the word (addr[1:0])
//     i_rd_word     word to extract from (loads) or merge into (sub-word stores)
//     i_wdata       store data; low byte/half used for SB/SH
//     o_load_data   selected lane, sign- or zero-extended (whole word for LW)
//     o_merge_data  i_rd_word with the addressed lane replaced by i_wdata
//     o_err         misaligned access or illegal funct3
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_we,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rd_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data,
  output logic        o_err
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [7:0]  w_merge_lane [4];

  assign w_byte = i_rd_word[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rd_word[31:16] : i_rd_word[15:0];

  always_comb begin
    o_load_data = i_rd_word;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
      F3_BU:   o_load_data = {24'd0, w_byte};
      F3_HU:   o_load_data = {16'd0, w_half};
      default: o_load_data = i_rd_word;
    endcase
  end

  // Per byte lane: SB replaces the single addressed lane with wdata[7:0];
  // SH replaces both lanes of the addressed half with wdata[15:0]; any other
  // code passes the full store word through.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic [7:0] w_rd_lane;
      logic       w_sel_b;
      logic       w_sel_h;

      assign w_rd_lane = i_rd_word[8*gi +: 8];
      assign w_sel_b   = (i_addr_lo == LANE);
      assign w_sel_h   = (i_addr_lo[1] == LANE[1]);

      assign w_merge_lane[gi] =
        (i_funct3 == F3_B) ? (w_sel_b ? i_wdata[7:0] : w_rd_lane) :
        (i_funct3 == F3_H) ? (w_sel_h ? i_wdata[8*(gi%2) +: 8] : w_rd_lane) :
                             i_wdata[8*gi +: 8];
    end
  endgenerate

  assign o_merge_data = {w_merge_lane[3], w_merge_lane[2], w_merge_lane[1], w_merge_lane[0]};

  always_comb begin
    o_err = 1'b0;
    if (i_we) begin
      case (i_funct3)
        F3_B:    o_err = 1'b0;
        F3_H:    o_err = i_addr_lo[0];
        F3_W:    o_err = |i_addr_lo;
        default: o_err = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        F3_B, F3_BU: o_err = 1'b0;
        F3_H, F3_HU: o_err = i_addr_lo[0];
        F3_W:        o_err = |i_addr_lo;
        default:     o_err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store initiator between the execute stage and a word-organised data
//   memory (async read, sync write, no byte enables). One request at a time;
//   sub-word stores are done as read-modify-write.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    lsu_ctrl_if.slave: request/response handshake and memory port
//
//   Latency from accept edge to resp_valid: load 2, SW 2, SB/SH 4, error 1.
// -----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_ctrl_if.slave    bus
);

  generate
    if (DATA_WIDTH != LSU_DW) begin : g_bad_width
      $error("lsu_ctrl supports DATA_WIDTH = 32 only");
    end
  endgenerate

  lsu_state_t               r_state;
  lsu_state_t               w_state_next;
  logic                     r_we;
  logic [2:0]               r_funct3;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH-1:0]    r_word;
  logic [DATA_WIDTH-1:0]    r_resp_rdata;
  logic                     r_resp_err;

  logic                     w_idle;
  logic                     w_accept;
  logic                     w_chk_we;
  logic [2:0]               w_chk_funct3;
  logic [1:0]               w_chk_addr_lo;
  logic [DATA_WIDTH-1:0]    w_align_word;
  logic [DATA_WIDTH-1:0]    w_load_data;
  logic [DATA_WIDTH-1:0]    w_merge_data;
  logic                     w_err;
  logic                     w_mem_active;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle && bus.req_valid;

  // The legality check must see the live request while idle (it decides the
  // next state at the accept edge); afterwards the captured copy is used.
  assign w_chk_we      = w_idle ? bus.req_we         : r_we;
  assign w_chk_funct3  = w_idle ? bus.req_funct3     : r_funct3;
  assign w_chk_addr_lo = w_idle ? bus.req_addr[1:0]  : r_addr[1:0];
  // Loads extract straight from the memory bus in READ; the merge works on
  // the word captured at the READ edge.
  assign w_align_word  = (r_state == MERGE) ? r_word : bus.mem_rd;

  lsu_align u_align (
    .i_funct3     (w_chk_funct3),
    .i_we         (w_chk_we),
    .i_addr_lo    (w_chk_addr_lo),
    .i_rd_word    (w_align_word),
    .i_wdata      (r_wdata),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data),
    .o_err        (w_err)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                          w_state_next = DONE;
          else if (!bus.req_we)               w_state_next = READ;
          else if (bus.req_funct3 == F3_W)    w_state_next = WRITE;
          else                                w_state_next = READ;
        end
      end
      READ:    w_state_next = r_we ? MERGE : DONE;
      MERGE:   w_state_next = WRITE;
      WRITE:   w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_word       <= '0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we     <= bus.req_we;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr;
            r_wdata  <= bus.req_wdata;
            // SW goes straight to WRITE, so the store word is the write data.
            r_word   <= bus.req_wdata;
            if (w_err) begin
              r_resp_rdata <= '0;
              r_resp_err   <= 1'b1;
            end
          end
        end
        READ: begin
          r_word <= bus.mem_rd;
          if (!r_we) begin
            r_resp_rdata <= w_load_data;
            r_resp_err   <= 1'b0;
          end
        end
        MERGE: r_word <= w_merge_data;
        WRITE: begin
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign w_mem_active = (r_state == READ) || (r_state == MERGE) || (r_state == WRITE);

  assign bus.req_ready  = w_idle;
  assign bus.resp_valid = (r_state == DONE);
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;
  assign bus.mem_addr   = w_mem_active ? {2'b00, r_addr[ADDRESS_WIDTH-1:2]} : '0;
  assign bus.mem_wr_en  = (r_state == WRITE);
  assign bus.mem_wd     = (r_state == WRITE) ? r_word : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Self-checking bench for lsu_ctrl. The reference keeps memory as a byte
//   array and derives results, errors and latencies from the RV32 rules.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  lsu_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: async read, sync write.
  logic [31:0] mem [0:63];
  int          wr_count = 0;
  logic [31:0] wr_addr = 0;
  logic [31:0] wr_data = 0;
  assign bus.mem_rd = mem[bus.mem_addr[5:0]];
  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wd;
      wr_count <= wr_count + 1;
      wr_addr  <= bus.mem_addr;
      wr_data  <= bus.mem_wd;
    end
  end

  // Reference model state.
  logic [7:0]  ref_b [0:255];
  logic [31:0] last_rdata = 0;
  logic [31:0] last_err = 0;
  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input bit we, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    if (we) legal = (f3 == B) || (f3 == H) || (f3 == W);
    else    legal = (f3 == B) || (f3 == H) || (f3 == W) || (f3 == BU) || (f3 == HU);
    if (!legal) return 1'b1;
    if (f3[1:0] == 2'b01 && a[0]) return 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input int idx);
    return {ref_b[idx*4+3], ref_b[idx*4+2], ref_b[idx*4+1], ref_b[idx*4]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_b[a + i]) << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  // One full request: checks the idle cycle before it, the busy cycles,
  // the response, its latency and the memory write it caused.
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    bit          e;
    int          exp_lat;
    logic [31:0] exp_rd;
    int          n;
    int          wc0;
    int          lat;
    bit          seen;
    e = ref_err(we, f3, a);
    exp_rd = 0;
    if (e)          exp_lat = 1;
    else if (!we) begin exp_lat = 2; exp_rd = ref_load(f3, a); end
    else begin
      exp_lat = (f3 == W) ? 2 : 4;
      n = (f3 == B) ? 1 : (f3 == H) ? 2 : 4;
      for (int i = 0; i < n; i++) ref_b[a + i] = wd[8*i +: 8];
    end

    @(negedge clk);
    check({tag, " idle_rdata_hold"}, bus.resp_rdata, last_rdata);
    check({tag, " idle_err_hold"}, 32'(bus.resp_err), last_err);
    check({tag, " idle_ready"}, 32'(bus.req_ready), 1);
    check({tag, " idle_mem_addr"}, bus.mem_addr, 0);
    check({tag, " idle_wr_en"}, 32'(bus.mem_wr_en), 0);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    wc0 = wr_count;
    @(posedge clk);
    #1;
    // Junk requests while busy must be ignored.
    bus.req_valid = 1'($urandom_range(0, 1)); bus.req_we = 1'($urandom_range(0, 1));
    bus.req_funct3 = 3'($urandom_range(0, 7)); bus.req_addr = $urandom; bus.req_wdata = $urandom;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid === 1'b1) seen = 1;
      else begin
        check({tag, " busy_ready"}, 32'(bus.req_ready), 0);
        bus.req_valid = 1'($urandom_range(0, 1)); bus.req_addr = $urandom;
      end
    end
    bus.req_valid = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, bus.resp_rdata, exp_rd);
    check({tag, " err"}, 32'(bus.resp_err), 32'(e));
    check({tag, " writes"}, wr_count - wc0, (we && !e) ? 1 : 0);
    if (we && !e) begin
      check({tag, " wr_addr"}, wr_addr, a >> 2);
      check({tag, " wr_data"}, wr_data, ref_word(a >> 2));
    end
    $display("[TB] %s we=%0d f3=%0d addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
             tag, we, f3, a, wd, bus.resp_rdata, bus.resp_err, lat);
    last_rdata = exp_rd;
    last_err = 32'(e);
  endtask

  initial begin
    int wc0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;

    // Reset values.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 1);
    check("rst resp_valid", 32'(bus.resp_valid), 0);
    check("rst resp_err", 32'(bus.resp_err), 0);
    check("rst resp_rdata", bus.resp_rdata, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst mem_wr_en", 32'(bus.mem_wr_en), 0);
    check("rst mem_wd", bus.mem_wd, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst req_ready", 32'(bus.req_ready), 1);

    // Fill words 0..15 so every later read has a known value.
    for (int w = 0; w < 16; w++) do_req(1, W, 32'(w * 4), $urandom, "fill");

    // Reset during the WRITE cycle of a SW.
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 1; bus.req_funct3 = W;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 0;
    @(negedge clk);
    check("midrst wr_en_in_write", 32'(bus.mem_wr_en), 1);
    check("midrst mem_addr", bus.mem_addr, 8);
    wc0 = wr_count;
    rst_n = 1'b0;
    #1;
    check("midrst wr_en_drop", 32'(bus.mem_wr_en), 0);
    check("midrst resp_valid", 32'(bus.resp_valid), 0);
    @(negedge clk);
    check("midrst no_write", wr_count - wc0, 0);
    check("midrst mem_unchanged", mem[8], ref_word(8));
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst after resp_valid", 32'(bus.resp_valid), 0);
      check("midrst after ready", 32'(bus.req_ready), 1);
    end
    last_rdata = 0; last_err = 0;

    // SW then LW.
    do_req(1, W, 32'h10, 32'hDEADBEEF, "sw");
    check("sw word_index", wr_addr, 4);
    do_req(0, W, 32'h10, 0, "lw");
    check("lw value", bus.resp_rdata, 32'hDEADBEEF);

    // Byte store and loads.
    do_req(1, W, 32'h10, 32'h11223344, "sw_init");
    do_req(1, B, 32'h12, 32'h000000AA, "sb");
    check("sb word", wr_data, 32'h11AA3344);
    do_req(0, B, 32'h12, 0, "lb");
    check("lb value", bus.resp_rdata, 32'hFFFFFFAA);
    do_req(0, BU, 32'h12, 0, "lbu");
    check("lbu value", bus.resp_rdata, 32'h000000AA);

    // Half store and loads.
    do_req(1, W, 32'h10, 32'h11223344, "sw_init");
    do_req(1, H, 32'h12, 32'h00008001, "sh");
    check("sh word", wr_data, 32'h80013344);
    do_req(0, H, 32'h12, 0, "lh");
    check("lh value", bus.resp_rdata, 32'hFFFF8001);
    do_req(0, HU, 32'h10, 0, "lhu");
    check("lhu value", bus.resp_rdata, 32'h00003344);

    // Errors.
    do_req(0, W, 32'h13, 0, "err_lw_mis");
    check("err_lw_mis err", 32'(bus.resp_err), 1);
    do_req(1, H, 32'h11, 32'h12345678, "err_sh_mis");
    check("err_sh_mis err", 32'(bus.resp_err), 1);
    do_req(0, 3'b011, 32'h10, 0, "err_f3");
    check("err_f3 err", 32'(bus.resp_err), 1);
    for (int w = 0; w < 16; w++) check("err mem_unchanged", mem[w], ref_word(w));

    // Randomized back-to-back traffic.
    for (int i = 0; i < 80; i++)
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 63)), $urandom, "rand");

    @(negedge clk);
    for (int w = 0; w < 16; w++) check("final mem", mem[w], ref_word(w));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
